mem_stage_param: RTL and testbench
==================================

// Module: mem_stage_param
// PURPOSE
//  Parametrised MEM pipeline stage: data-memory access plus MEM/WB pipeline register.
//  Successor to the fixed 32-bit, two-phase-clock MEM stage: one clock, configurable widths and depth.
//  Configurable multi-cycle memory latency with a stall handshake to upstream stages.
//  Sits between the EX/MEM register and the writeback stage of the pipelined core.
// PARAMETERS
//  DATA_W       32  data, ALU-result and store width
//  ADDR_W       8   word-address bits; memory depth = 2**ADDR_W words
//  REG_W        5   destination register index width
//  WB_W         2   writeback-select control width
//  MEM_LATENCY  1   cycles per memory access (>=1)
// PORTS
//  clock                  in   1       single rising-edge clock
//  reset                  in   1       synchronous, active-high reset
//  valid_MEMORY           in   1       instruction present in MEM stage
//  MEMORY_READ            in   1       load request
//  MEMORY_WRITE           in   1       store request
//  WRITEBACK_MEMORY       in   WB_W    writeback select, passed to WB
//  destination_MEMORY     in   REG_W   destination register, passed to WB
//  result_ALU1_MEMORY     in   DATA_W  ALU result 1; low ADDR_W bits = word address
//  result_ALU2_MEMORY     in   DATA_W  ALU result 2, passed to WB
//  store_input            in   DATA_W  store data
//  stall_MEMORY           out  1       hold upstream; inputs must stay stable while high
//  valid_WRITEBACK        out  1       WB register holds a valid instruction
//  MEMORY_READ_WRITEBACK  out  1       registered load flag
//  WRITEBACK_WRITEBACK    out  WB_W    registered writeback select
//  destination_WRITEBACK  out  REG_W   registered destination
//  memory_out_WRITEBACK   out  DATA_W  registered load data (0 if not a load)
//  result_ALU1_WRITEBACK  out  DATA_W  registered ALU result 1
//  result_ALU2_WRITEBACK  out  DATA_W  registered ALU result 2
//  fault_WRITEBACK        out  1       address fault flag (present only with MEM_FAULT_CHECK_EN)
// BEHAVIOUR
//  Reset: every WB-side output = 0, stall_MEMORY = 0, FSM = IDLE, wait counter = 0.
//  Memory array contents are NOT affected by reset.
//  Memory op = valid_MEMORY & (MEMORY_READ | MEMORY_WRITE).
//  READ and WRITE both high: treat as a store; MEMORY_READ_WRITEBACK = 0.
//  Non-memory valid instruction: passes to WB in 1 cycle, no stall.
//  MEM_LATENCY = 1:
//   - Access completes at the edge ending the accept cycle; no stall.
//   - Full throughput, one op per cycle.
//  MEM_LATENCY = L > 1:
//   - FSM IDLE -> WAIT on accepting a memory op.
//   - stall_MEMORY is high combinationally from the accept cycle for L-1 cycles.
//   - Counter counts 1..L-1; at L-1, FSM WAIT -> IDLE and stall drops.
//   - WB register loads at the edge ending cycle L.
//   - valid_WRITEBACK = 0 (bubble) at the edges ending each stall cycle.
//  Store commits to memory exactly once, at the completing edge.
//  Load data is read from the address at the completing edge.
//  Read-after-write to the same address in consecutive ops returns the newly stored data.
//  Address = result_ALU1_MEMORY[ADDR_W-1:0]; upper bits are ignored unless fault checking is on.
//  reset during WAIT: abort immediately; an uncommitted store is dropped; outputs return to reset values.
//  valid_MEMORY = 0: WB register loads a bubble (valid_WRITEBACK = 0, other fields 0).
// CONFIGURATION
//  MEM_FAULT_CHECK_EN defined:
//   - Op with any nonzero bit in result_ALU1_MEMORY[DATA_W-1:ADDR_W] is out of range.
//   - Out-of-range store is suppressed.
//   - Out-of-range load returns 0.
//   - fault_WRITEBACK = 1 with the instruction; latency is unchanged.
//  MEM_FAULT_CHECK_EN undefined: no fault_WRITEBACK port; address silently truncated.
// TESTING
//  T1 reset: reset=1 for 2 cycles mid-stream -> all WB outputs 0, stall_MEMORY=0.
//  T2 L=1: store 0x8 to 0x15, then load 0x15 next cycle
//     -> memory_out_WRITEBACK=0x8, MEMORY_READ_WRITEBACK=1, destination_WRITEBACK=5.
//  T3 L=3: load 0x15
//     -> stall_MEMORY high for exactly 2 cycles; 2 bubbles on valid_WRITEBACK; data on 3rd edge.
//  T4 passthrough: ALU op, result_ALU1=0x2, ALU2=0x1, WB sel=3, dest=0
//     -> identical values in WB one cycle later; memory_out_WRITEBACK=0.
//  T5 L=4: reset asserted in 2nd stall cycle of a store 0xAB to 0x7
//     -> later load of 0x7 returns the prior value, not 0xAB.
//  T6 MEM_FAULT_CHECK_EN, ADDR_W=8: store 0x55 to 0x115
//     -> fault_WRITEBACK=1; word 0x15 unchanged on readback.

Source files
------------

// File: rtl/mem_stage_param_if.sv
// MEM-stage bus: EX/MEM inputs, stall back-pressure and MEM/WB register outputs.
// fault_WRITEBACK exists only when MEM_FAULT_CHECK_EN is defined.
interface mem_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
);
  logic              valid_MEMORY;
  logic              MEMORY_READ;
  logic              MEMORY_WRITE;
  logic [WB_W-1:0]   WRITEBACK_MEMORY;
  logic [REG_W-1:0]  destination_MEMORY;
  logic [DATA_W-1:0] result_ALU1_MEMORY;
  logic [DATA_W-1:0] result_ALU2_MEMORY;
  logic [DATA_W-1:0] store_input;
  logic              stall_MEMORY;
  logic              valid_WRITEBACK;
  logic              MEMORY_READ_WRITEBACK;
  logic [WB_W-1:0]   WRITEBACK_WRITEBACK;
  logic [REG_W-1:0]  destination_WRITEBACK;
  logic [DATA_W-1:0] memory_out_WRITEBACK;
  logic [DATA_W-1:0] result_ALU1_WRITEBACK;
  logic [DATA_W-1:0] result_ALU2_WRITEBACK;
`ifdef MEM_FAULT_CHECK_EN
  logic              fault_WRITEBACK;
`endif

  modport master (
    output valid_MEMORY, MEMORY_READ, MEMORY_WRITE, WRITEBACK_MEMORY,
           destination_MEMORY, result_ALU1_MEMORY, result_ALU2_MEMORY, store_input,
    input  stall_MEMORY, valid_WRITEBACK, MEMORY_READ_WRITEBACK, WRITEBACK_WRITEBACK,
           destination_WRITEBACK, memory_out_WRITEBACK, result_ALU1_WRITEBACK,
           result_ALU2_WRITEBACK
`ifdef MEM_FAULT_CHECK_EN
    , input fault_WRITEBACK
`endif
  );

  modport slave (
    input  valid_MEMORY, MEMORY_READ, MEMORY_WRITE, WRITEBACK_MEMORY,
           destination_MEMORY, result_ALU1_MEMORY, result_ALU2_MEMORY, store_input,
    output stall_MEMORY, valid_WRITEBACK, MEMORY_READ_WRITEBACK, WRITEBACK_WRITEBACK,
           destination_WRITEBACK, memory_out_WRITEBACK, result_ALU1_WRITEBACK,
           result_ALU2_WRITEBACK
`ifdef MEM_FAULT_CHECK_EN
    , output fault_WRITEBACK
`endif
  );
endinterface

// File: rtl/mem_stage_param.sv
// MEM pipeline stage: data memory with MEM_LATENCY-cycle access plus MEM/WB register.
// Define MEM_FAULT_CHECK_EN to flag and suppress accesses with nonzero upper address bits.
module mem_stage_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int MEM_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  mem_stage_param_if.slave bus
);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              mem_op, is_store, is_load, fault, complete, stall, adv;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // READ+WRITE together is a store
  assign mem_op   = bus.valid_MEMORY & (bus.MEMORY_READ | bus.MEMORY_WRITE);
  assign is_store = bus.MEMORY_WRITE;
  assign is_load  = bus.MEMORY_READ & ~bus.MEMORY_WRITE;
  assign addr     = bus.result_ALU1_MEMORY[ADDR_W-1:0];

`ifdef MEM_FAULT_CHECK_EN
  assign fault = |bus.result_ALU1_MEMORY[DATA_W-1:ADDR_W];
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == WAIT) cnt <= (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
      else                   cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (MEM_LATENCY > 1 && mem_op) state_nxt = WAIT;
      WAIT:    if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final WAIT cycle (cnt == LAST) is the un-stalled completing cycle
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    if (MEM_LATENCY == 1) begin
      complete = mem_op;
    end else begin
      case (state)
        IDLE: stall = mem_op;
        WAIT: if (cnt == LAST) complete = 1'b1; else stall = 1'b1;
        default: ;
      endcase
    end
    if (reset) stall = 1'b0;
  end

  assign bus.stall_MEMORY = stall;
  assign adv = bus.valid_MEMORY & (~mem_op | complete);

  // Array is not reset; a store caught by reset is dropped
  always_ff @(posedge clock) begin
    if (!reset && complete && is_store && !fault) mem[addr] <= bus.store_input;
  end

  always_ff @(posedge clock) begin
    if (reset || !adv) begin
      bus.valid_WRITEBACK       <= 1'b0;
      bus.MEMORY_READ_WRITEBACK <= 1'b0;
      bus.WRITEBACK_WRITEBACK   <= '0;
      bus.destination_WRITEBACK <= '0;
      bus.memory_out_WRITEBACK  <= '0;
      bus.result_ALU1_WRITEBACK <= '0;
      bus.result_ALU2_WRITEBACK <= '0;
`ifdef MEM_FAULT_CHECK_EN
      bus.fault_WRITEBACK       <= 1'b0;
`endif
    end else begin
      bus.valid_WRITEBACK       <= 1'b1;
      bus.MEMORY_READ_WRITEBACK <= is_load;
      bus.WRITEBACK_WRITEBACK   <= bus.WRITEBACK_MEMORY;
      bus.destination_WRITEBACK <= bus.destination_MEMORY;
      bus.memory_out_WRITEBACK  <= (is_load && !fault) ? mem[addr] : '0;
      bus.result_ALU1_WRITEBACK <= bus.result_ALU1_MEMORY;
      bus.result_ALU2_WRITEBACK <= bus.result_ALU2_MEMORY;
`ifdef MEM_FAULT_CHECK_EN
      bus.fault_WRITEBACK       <= mem_op & fault;
`endif
    end
  end
endmodule

// File: tb/tb_mem_stage_param.sv
// Directed bench: three stage instances with MEM_LATENCY 1, 3 and 4 sharing clock and reset.
module tb_mem_stage_param;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mem_stage_param_if #(.DATA_W(32), .REG_W(5), .WB_W(2)) ia ();
  mem_stage_param_if #(.DATA_W(32), .REG_W(5), .WB_W(2)) ib ();
  mem_stage_param_if #(.DATA_W(32), .REG_W(5), .WB_W(2)) ic ();

  mem_stage_param #(.DATA_W(32), .ADDR_W(8), .REG_W(5), .WB_W(2), .MEM_LATENCY(1))
    dut_a (.clock(clock), .reset(reset), .bus(ia));
  mem_stage_param #(.DATA_W(32), .ADDR_W(8), .REG_W(5), .WB_W(2), .MEM_LATENCY(3))
    dut_b (.clock(clock), .reset(reset), .bus(ib));
  mem_stage_param #(.DATA_W(32), .ADDR_W(8), .REG_W(5), .WB_W(2), .MEM_LATENCY(4))
    dut_c (.clock(clock), .reset(reset), .bus(ic));

  task automatic drv_a(input logic v, rd, wr, input logic [1:0] wb, input logic [4:0] d,
                       input logic [31:0] a1, a2, st);
    ia.valid_MEMORY = v; ia.MEMORY_READ = rd; ia.MEMORY_WRITE = wr; ia.WRITEBACK_MEMORY = wb;
    ia.destination_MEMORY = d; ia.result_ALU1_MEMORY = a1; ia.result_ALU2_MEMORY = a2;
    ia.store_input = st;
  endtask

  task automatic drv_b(input logic v, rd, wr, input logic [4:0] d, input logic [31:0] a1, st);
    ib.valid_MEMORY = v; ib.MEMORY_READ = rd; ib.MEMORY_WRITE = wr; ib.WRITEBACK_MEMORY = 2'd1;
    ib.destination_MEMORY = d; ib.result_ALU1_MEMORY = a1; ib.result_ALU2_MEMORY = 32'h0;
    ib.store_input = st;
  endtask

  task automatic drv_c(input logic v, rd, wr, input logic [4:0] d, input logic [31:0] a1, st);
    ic.valid_MEMORY = v; ic.MEMORY_READ = rd; ic.MEMORY_WRITE = wr; ic.WRITEBACK_MEMORY = 2'd1;
    ic.destination_MEMORY = d; ic.result_ALU1_MEMORY = a1; ic.result_ALU2_MEMORY = 32'h0;
    ic.store_input = st;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv_a(0, 0, 0, 0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0, 0); drv_c(0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    // stream: ALU op on a, load started on b (b enters WAIT)
    drv_a(1, 0, 0, 2'd2, 5'd9, 32'h33, 32'h44, 0);
    drv_b(1, 1, 0, 5'd3, 32'h40, 0);
    tick();
    checks++; if (ia.valid_WRITEBACK !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", ia.valid_WRITEBACK); end
    reset = 1'b1; #1;
    checks++; if (ib.stall_MEMORY !== 1'b0) begin errors++; $display("FAIL rst_stall_comb got %b exp 0", ib.stall_MEMORY); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({ia.valid_WRITEBACK, ia.MEMORY_READ_WRITEBACK, ia.WRITEBACK_WRITEBACK, ia.destination_WRITEBACK,
           ia.memory_out_WRITEBACK, ia.result_ALU1_WRITEBACK, ia.result_ALU2_WRITEBACK} !== '0) begin
        errors++; $display("FAIL rst_a_outputs cycle %0d got v=%b a1=%h a2=%h exp 0", k,
                           ia.valid_WRITEBACK, ia.result_ALU1_WRITEBACK, ia.result_ALU2_WRITEBACK);
      end
      checks++;
      if ({ib.valid_WRITEBACK, ib.stall_MEMORY, ib.destination_WRITEBACK, ib.result_ALU1_WRITEBACK} !== '0) begin
        errors++; $display("FAIL rst_b_outputs cycle %0d got v=%b stall=%b exp 0", k,
                           ib.valid_WRITEBACK, ib.stall_MEMORY);
      end
    end
    drv_a(0, 0, 0, 0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_l1_store_load();
    drv_a(1, 0, 1, 2'd0, 5'd0, 32'h15, 32'h0, 32'h8); #1;
    checks++; if (ia.stall_MEMORY !== 1'b0) begin errors++; $display("FAIL l1_store_stall got %b exp 0", ia.stall_MEMORY); end
    tick();
    checks++; if (ia.valid_WRITEBACK !== 1'b1 || ia.MEMORY_READ_WRITEBACK !== 1'b0)
      begin errors++; $display("FAIL l1_store_wb got v=%b rd=%b exp 1 0", ia.valid_WRITEBACK, ia.MEMORY_READ_WRITEBACK); end
    drv_a(1, 1, 0, 2'd1, 5'd5, 32'h15, 32'h0, 32'h0);
    tick();
    checks++; if (ia.memory_out_WRITEBACK !== 32'h8) begin errors++; $display("FAIL l1_load_data got %h exp 8", ia.memory_out_WRITEBACK); end
    checks++; if (ia.MEMORY_READ_WRITEBACK !== 1'b1) begin errors++; $display("FAIL l1_load_rd got %b exp 1", ia.MEMORY_READ_WRITEBACK); end
    checks++; if (ia.destination_WRITEBACK !== 5'd5) begin errors++; $display("FAIL l1_load_dest got %0d exp 5", ia.destination_WRITEBACK); end
    // READ+WRITE together: stored, not flagged as load
    drv_a(1, 1, 1, 2'd0, 5'd1, 32'h16, 32'h0, 32'h77);
    tick();
    checks++; if (ia.MEMORY_READ_WRITEBACK !== 1'b0 || ia.memory_out_WRITEBACK !== 32'h0)
      begin errors++; $display("FAIL l1_rdwr_flags got rd=%b mo=%h exp 0 0", ia.MEMORY_READ_WRITEBACK, ia.memory_out_WRITEBACK); end
    drv_a(1, 1, 0, 2'd0, 5'd2, 32'h16, 32'h0, 32'h0);
    tick();
    checks++; if (ia.memory_out_WRITEBACK !== 32'h77) begin errors++; $display("FAIL l1_rdwr_stored got %h exp 77", ia.memory_out_WRITEBACK); end
    drv_a(0, 1, 0, 2'd3, 5'd7, 32'h15, 32'h9, 32'h0);
    tick();
    checks++;
    if ({ia.valid_WRITEBACK, ia.MEMORY_READ_WRITEBACK, ia.destination_WRITEBACK, ia.memory_out_WRITEBACK,
         ia.result_ALU1_WRITEBACK, ia.result_ALU2_WRITEBACK, ia.WRITEBACK_WRITEBACK} !== '0)
      begin errors++; $display("FAIL l1_bubble got v=%b mo=%h a1=%h exp 0", ia.valid_WRITEBACK, ia.memory_out_WRITEBACK, ia.result_ALU1_WRITEBACK); end
  endtask

  task automatic test_passthrough();
    drv_a(1, 0, 0, 2'd3, 5'd0, 32'h2, 32'h1, 32'h0); #1;
    checks++; if (ia.stall_MEMORY !== 1'b0) begin errors++; $display("FAIL pass_stall got %b exp 0", ia.stall_MEMORY); end
    tick();
    checks++;
    if (ia.valid_WRITEBACK !== 1'b1 || ia.result_ALU1_WRITEBACK !== 32'h2 || ia.result_ALU2_WRITEBACK !== 32'h1 ||
        ia.WRITEBACK_WRITEBACK !== 2'd3 || ia.destination_WRITEBACK !== 5'd0 || ia.memory_out_WRITEBACK !== 32'h0 ||
        ia.MEMORY_READ_WRITEBACK !== 1'b0)
      begin errors++; $display("FAIL pass_fields got v=%b a1=%h a2=%h wb=%0d d=%0d mo=%h exp 1 2 1 3 0 0",
        ia.valid_WRITEBACK, ia.result_ALU1_WRITEBACK, ia.result_ALU2_WRITEBACK, ia.WRITEBACK_WRITEBACK,
        ia.destination_WRITEBACK, ia.memory_out_WRITEBACK); end
    drv_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_l3_load();
    int stalls = 0;
    int bubbles = 0;
    drv_b(1, 0, 1, 5'd0, 32'h15, 32'h3C);
    tick(); tick(); tick();
    drv_b(1, 1, 0, 5'd6, 32'h15, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (ib.stall_MEMORY === 1'b1) stalls++;
      tick();
      if (k < 2 && ib.valid_WRITEBACK === 1'b0) bubbles++;
    end
    checks++; if (stalls != 2) begin errors++; $display("FAIL l3_stall_cycles got %0d exp 2", stalls); end
    checks++; if (bubbles != 2) begin errors++; $display("FAIL l3_bubbles got %0d exp 2", bubbles); end
    checks++; if (ib.valid_WRITEBACK !== 1'b1 || ib.memory_out_WRITEBACK !== 32'h3C || ib.destination_WRITEBACK !== 5'd6)
      begin errors++; $display("FAIL l3_load_data got v=%b mo=%h d=%0d exp 1 3c 6", ib.valid_WRITEBACK, ib.memory_out_WRITEBACK, ib.destination_WRITEBACK); end
    drv_b(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (ib.valid_WRITEBACK !== 1'b0 || ib.stall_MEMORY !== 1'b0)
      begin errors++; $display("FAIL l3_idle_after got v=%b stall=%b exp 0 0", ib.valid_WRITEBACK, ib.stall_MEMORY); end
  endtask

  task automatic test_reset_abort();
    drv_c(1, 0, 1, 5'd0, 32'h7, 32'h11);
    tick(); tick(); tick(); tick();
    drv_c(1, 0, 1, 5'd0, 32'h7, 32'hAB);
    tick();
    checks++; if (ic.stall_MEMORY !== 1'b1) begin errors++; $display("FAIL l4_stall_wait got %b exp 1", ic.stall_MEMORY); end
    reset = 1'b1;
    tick();
    checks++; if (ic.valid_WRITEBACK !== 1'b0 || ic.stall_MEMORY !== 1'b0)
      begin errors++; $display("FAIL l4_abort got v=%b stall=%b exp 0 0", ic.valid_WRITEBACK, ic.stall_MEMORY); end
    drv_c(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    drv_c(1, 1, 0, 5'd4, 32'h7, 32'h0);
    tick(); tick(); tick(); tick();
    checks++; if (ic.valid_WRITEBACK !== 1'b1 || ic.memory_out_WRITEBACK !== 32'h11)
      begin errors++; $display("FAIL l4_prior_value got v=%b mo=%h exp 1 11", ic.valid_WRITEBACK, ic.memory_out_WRITEBACK); end
    drv_c(0, 0, 0, 0, 0, 0);
    tick();
  endtask

`ifdef MEM_FAULT_CHECK_EN
  task automatic test_fault();
    drv_a(1, 0, 1, 2'd0, 5'd0, 32'h115, 32'h0, 32'h55);
    tick();
    checks++; if (ia.fault_WRITEBACK !== 1'b1 || ia.valid_WRITEBACK !== 1'b1)
      begin errors++; $display("FAIL fault_flag got f=%b v=%b exp 1 1", ia.fault_WRITEBACK, ia.valid_WRITEBACK); end
    drv_a(1, 1, 0, 2'd0, 5'd3, 32'h15, 32'h0, 32'h0);
    tick();
    checks++; if (ia.memory_out_WRITEBACK !== 32'h8 || ia.fault_WRITEBACK !== 1'b0)
      begin errors++; $display("FAIL fault_readback got mo=%h f=%b exp 8 0", ia.memory_out_WRITEBACK, ia.fault_WRITEBACK); end
    drv_a(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_l1_store_load();
    test_passthrough();
    test_l3_load();
    test_reset_abort();
`ifdef MEM_FAULT_CHECK_EN
    test_fault();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
